fmlbrg_linectl: RTL and testbench

- Cache-line transfer engine for the FML 8x16 bridge.
- Sits between the bridge's tag/control logic and both the FML bus and the primary (read-write) port of the bridge data memory.
- On command it writes back one dirty 8-word line from the data memory to FML, then refills the same cache slot from a new FML line, or does either half alone.
- The data memory secondary (read-only) port stays with the CPU side and is never touched by this block.

---
 rtl/fmlbrg_linectl_pkg.sv | 24 ++
 rtl/fmlbrg_linectl.sv | 163 ++++++++++++++++
 tb/tb_fmlbrg_linectl.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmlbrg_linectl_pkg.sv
// Shared definitions for the FML bridge cache-line transfer engine.
// Holds the controller state encoding and the burst/line geometry constants
// used by fmlbrg_linectl.
package fmlbrg_linectl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_REQ  = 3'd1,
    S_WB_DATA = 3'd2,
    S_RF_REQ  = 3'd3,
    S_RF_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int         FML_BURST_LEN = 8;    // 16-bit words per FML burst
  localparam int         LINE_BYTES    = 16;   // bytes per cache line
  localparam logic [1:0] FML_SEL_FULL  = 2'b11;

  localparam int WORD_BITS     = $clog2(FML_BURST_LEN);
  localparam int LINE_OFS_BITS = $clog2(LINE_BYTES);

  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(FML_BURST_LEN - 1);

endpackage

// File: rtl/fmlbrg_linectl.sv
// Cache-line transfer engine for the FML 8x16 bridge.
// On a command it writes one 8-word line from the data memory primary port
// out to FML (writeback), then fills the same slot from another FML line
// (refill); either half may be requested alone, or neither (done only).
//
// Ports:
//   sys_clk, sys_rst_n        clock, synchronous active-low reset
//   req_valid/evict/refill    command strobe and operation flags (IDLE only)
//   req_index                 cache slot index
//   evict_ladr, refill_ladr   FML line addresses for the two halves
//   busy, done                command in progress / one-cycle completion
//   dm_a, dm_we, dm_di, dm_do data memory primary port (read latency 1)
//   fml_*                     FML master port
//   dbg_state                 current controller state
//
// Handshake: a command is taken on any rising edge where req_valid=1 and
// busy=0; req_valid while busy=1 is dropped. On FML, fml_stb is held until
// the cycle fml_ack=1; the burst data then runs with no further handshake.
module fmlbrg_linectl
  import fmlbrg_linectl_pkg::*;
#(
  parameter int fml_depth = 26,
  parameter int depth     = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   req_valid,
  input  logic                   req_evict,
  input  logic                   req_refill,
  input  logic [depth-4:0]       req_index,
  input  logic [fml_depth-5:0]   evict_ladr,
  input  logic [fml_depth-5:0]   refill_ladr,
  output logic                   busy,
  output logic                   done,
  output logic [depth-1:0]       dm_a,
  output logic [1:0]             dm_we,
  output logic [15:0]            dm_di,
  input  logic [15:0]            dm_do,
  output logic [fml_depth-1:0]   fml_adr,
  output logic                   fml_stb,
  output logic                   fml_we,
  output logic [1:0]             fml_sel,
  output logic [15:0]            fml_do,
  input  logic [15:0]            fml_di,
  input  logic                   fml_ack,
  output logic [2:0]             dbg_state
);

  localparam int IW = depth - WORD_BITS;
  localparam int LW = fml_depth - LINE_OFS_BITS;

  state_t                 r_state, w_next;
  logic [WORD_BITS-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [IW-1:0]          r_idx;
  logic [LW-1:0]          r_refill_ladr;
  logic                   r_refill;
  logic                   r_fml_stb, r_fml_we;
  logic [fml_depth-1:0]   r_fml_adr, w_adr_nxt;
  logic [depth-1:0]       w_dm_a;
  logic                   w_accept;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_cnt_inc = r_cnt + WORD_BITS'(1);

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_adr_nxt = r_fml_adr;
    w_dm_a    = {r_idx, r_cnt};
    case (r_state)
      S_IDLE: begin
        // Word 0 of the requested slot is addressed already, so its data is
        // on dm_do by the earliest possible writeback ack.
        w_dm_a    = {req_index, {WORD_BITS{1'b0}}};
        w_cnt_nxt = '0;
        if (req_valid) begin
          if (req_evict) begin
            w_next    = S_WB_REQ;
            w_adr_nxt = {evict_ladr, {LINE_OFS_BITS{1'b0}}};
          end else if (req_refill) begin
            w_next    = S_RF_REQ;
            w_adr_nxt = {refill_ladr, {LINE_OFS_BITS{1'b0}}};
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_WB_REQ: begin
        if (fml_ack) begin
          // Read one word ahead: the FML slave takes a word every cycle
          // from the ack onward and dm_do lags dm_a by a cycle.
          w_dm_a    = {r_idx, w_cnt_inc};
          w_cnt_nxt = w_cnt_inc;
          w_next    = S_WB_DATA;
        end
      end
      S_WB_DATA: begin
        // On the last word this pre-reads word 0 again; it is never used.
        w_dm_a    = {r_idx, w_cnt_inc};
        w_cnt_nxt = w_cnt_inc;
        if (r_cnt == LAST_WORD) begin
          if (r_refill) begin
            w_next    = S_RF_REQ;
            w_adr_nxt = {r_refill_ladr, {LINE_OFS_BITS{1'b0}}};
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_RF_REQ: begin
        if (fml_ack) begin
          w_cnt_nxt = '0;
          w_next    = S_RF_DATA;
        end
      end
      S_RF_DATA: begin
        w_cnt_nxt = w_cnt_inc;
        if (r_cnt == LAST_WORD) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_refill_ladr <= '0;
      r_refill      <= 1'b0;
      r_fml_stb     <= 1'b0;
      r_fml_we      <= 1'b0;
      r_fml_adr     <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      r_fml_adr <= w_adr_nxt;
      // Strobe is registered from the next state so it rises together with
      // entry to a request state and falls on the edge after the ack.
      r_fml_stb <= (w_next == S_WB_REQ) || (w_next == S_RF_REQ);
      r_fml_we  <= (w_next == S_WB_REQ);
      if (w_accept) begin
        r_idx         <= req_index;
        r_refill_ladr <= refill_ladr;
        r_refill      <= req_refill;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign dm_a      = w_dm_a;
  assign dm_we     = (r_state == S_RF_DATA) ? FML_SEL_FULL : 2'b00;
  assign dm_di     = fml_di;
  assign fml_do    = dm_do;
  assign fml_adr   = r_fml_adr;
  assign fml_stb   = r_fml_stb;
  assign fml_we    = r_fml_we;
  assign fml_sel   = FML_SEL_FULL;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fmlbrg_linectl.sv
`timescale 1ns/1ps
module tb_fmlbrg_linectl;
  import fmlbrg_linectl_pkg::*;

  localparam int FD = 26;
  localparam int DP = 8;
  localparam int IW = DP - 3;
  localparam int LW = FD - 4;

  // clock / reset / DUT
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic req_valid, req_evict, req_refill;
  logic [IW-1:0] req_index;
  logic [LW-1:0] evict_ladr, refill_ladr;
  logic busy, done;
  logic [DP-1:0] dm_a;
  logic [1:0] dm_we;
  logic [15:0] dm_di, dm_do;
  logic [FD-1:0] fml_adr;
  logic fml_stb, fml_we;
  logic [1:0] fml_sel;
  logic [15:0] fml_do, fml_di;
  logic fml_ack;
  logic [2:0] dbg_state;

  always #5 sys_clk = ~sys_clk;

  fmlbrg_linectl #(.fml_depth(FD), .depth(DP)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_evict(req_evict), .req_refill(req_refill),
    .req_index(req_index), .evict_ladr(evict_ladr), .refill_ladr(refill_ladr),
    .busy(busy), .done(done),
    .dm_a(dm_a), .dm_we(dm_we), .dm_di(dm_di), .dm_do(dm_do),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_sel(fml_sel),
    .fml_do(fml_do), .fml_di(fml_di), .fml_ack(fml_ack),
    .dbg_state(dbg_state)
  );

  // data memory with registered-address read and a bench preload port
  logic [15:0] mem [256];
  logic        pl_we;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;

  always @(posedge sys_clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else begin
      if (dm_we[0]) mem[dm_a][7:0]  <= dm_di[7:0];
      if (dm_we[1]) mem[dm_a][15:8] <= dm_di[15:8];
    end
    dm_do <= mem[dm_a];
  end

  // scoreboard / reference model state
  int total = 0;
  int bad   = 0;
  logic [15:0] mem_exp [256];
  logic [15:0] rdat [8];

  logic [FD-1:0] exp_adr_q[$];
  logic          exp_we_q[$];
  logic [15:0]   exp_wd_q[$];
  logic [7:0]    exp_wa_q[$];
  logic [15:0]   exp_wdd_q[$];
  int            exp_wc_q[$];
  int            exp_done_c;

  // observations from the last command
  logic [FD-1:0] obs_adr_q[$];
  logic          obs_we_q[$];
  logic [1:0]    obs_sel_q[$];
  int            obs_ack_q[$];
  logic [15:0]   obs_wd_q[$];
  logic [7:0]    obs_wa_q[$];
  logic [15:0]   obs_wdd_q[$];
  logic [1:0]    obs_wwe_q[$];
  int            obs_wc_q[$];
  int            obs_done_c, obs_done_n, obs_stb_n;
  logic [2:0]    rst_state;
  logic          rst_stb, rst_busy;
  logic [1:0]    rst_we;

  // Reference: cycles counted from the acceptance edge. A strobe first
  // shows in cycle 1; a write burst occupies ack..ack+7, a read burst
  // delivers words in ack+1..ack+8; done follows the last data cycle.
  task automatic model_cmd(input logic ev, input logic rf, input int idx,
                           input logic [LW-1:0] ea, input logic [LW-1:0] ra,
                           input int de, input int dr, input int nwords);
    int t, ack;
    exp_adr_q.delete(); exp_we_q.delete(); exp_wd_q.delete();
    exp_wa_q.delete(); exp_wdd_q.delete(); exp_wc_q.delete();
    t = 1;
    if (ev) begin
      exp_adr_q.push_back({ea, 4'h0});
      exp_we_q.push_back(1'b1);
      for (int k = 0; k < 8; k++) exp_wd_q.push_back(mem_exp[idx*8 + k]);
      t = t + de + 8;
    end
    if (rf) begin
      ack = t + dr;
      exp_adr_q.push_back({ra, 4'h0});
      exp_we_q.push_back(1'b0);
      for (int i = 0; i < nwords; i++) begin
        mem_exp[idx*8 + i] = rdat[i];
        exp_wa_q.push_back(8'(idx*8 + i));
        exp_wdd_q.push_back(rdat[i]);
        exp_wc_q.push_back(ack + 1 + i);
      end
      t = ack + 9;
    end
    exp_done_c = t;
  endtask

  // driver: issues one command and plays the FML slave
  task automatic run_cmd(input logic ev, input logic rf, input int idx,
                         input logic [LW-1:0] ea, input logic [LW-1:0] ra,
                         input int de, input int dr, input int spur_c, input int rst_c);
    int wait_n, ack_c, bw, nb, last_c;
    obs_adr_q.delete(); obs_we_q.delete(); obs_sel_q.delete(); obs_ack_q.delete();
    obs_wd_q.delete(); obs_wa_q.delete(); obs_wdd_q.delete(); obs_wwe_q.delete();
    obs_wc_q.delete();
    obs_done_c = -1; obs_done_n = 0; obs_stb_n = 0;
    @(negedge sys_clk);
    req_valid = 1'b1; req_evict = ev; req_refill = rf;
    req_index = idx[IW-1:0]; evict_ladr = ea; refill_ladr = ra;
    wait_n = 0; ack_c = -100; bw = 0; nb = 0; last_c = 200;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge sys_clk);
      req_valid = (c == spur_c) || (c == spur_c + 1);
      if (c == spur_c) begin req_evict = 1'b1; req_refill = 1'b1; end
      sys_rst_n = !(c == rst_c);
      fml_ack = 1'b0;
      fml_di  = 16'($urandom);
      if (fml_stb && c > ack_c) begin
        if (wait_n == ((ev && nb == 0) ? de : dr)) begin
          fml_ack = 1'b1; ack_c = c; bw = int'(fml_we); nb++; wait_n = 0;
        end else wait_n++;
      end
      if (bw == 0 && c >= ack_c + 1 && c <= ack_c + 8) fml_di = rdat[c - ack_c - 1];
      #1;
      if (fml_stb) obs_stb_n++;
      if (c == ack_c) begin
        obs_adr_q.push_back(fml_adr); obs_we_q.push_back(fml_we);
        obs_sel_q.push_back(fml_sel); obs_ack_q.push_back(c);
      end
      if (bw != 0 && c >= ack_c && c <= ack_c + 7) obs_wd_q.push_back(fml_do);
      if (dm_we != 2'b00) begin
        obs_wa_q.push_back(dm_a); obs_wdd_q.push_back(dm_di);
        obs_wwe_q.push_back(dm_we); obs_wc_q.push_back(c);
      end
      if (done) begin
        obs_done_n++;
        if (obs_done_c < 0) begin obs_done_c = c; last_c = c + 2; end
      end
      if (c == rst_c + 1) begin
        rst_state = dbg_state; rst_stb = fml_stb; rst_we = dm_we; rst_busy = busy;
        last_c = c + 3;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic preload(input int a, input logic [15:0] d);
    @(negedge sys_clk);
    pl_we = 1'b1; pl_a = 8'(a); pl_d = d; mem_exp[a] = d;
    @(negedge sys_clk);
    pl_we = 1'b0;
  endtask

  task automatic preload_all();
    for (int a = 0; a < 256; a++) begin
      @(negedge sys_clk);
      pl_we = 1'b1; pl_a = 8'(a); pl_d = 16'($urandom); mem_exp[a] = pl_d;
    end
    @(negedge sys_clk);
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (dm_we !== 2'b00) begin bad++; $display("FAIL reset_dm_we got=%b exp=00", dm_we); end
    total++; if (fml_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b exp=0", fml_stb); end
    total++; if (fml_we !== 1'b0) begin bad++; $display("FAIL reset_fml_we got=%b exp=0", fml_we); end
    total++; if (fml_adr !== '0) begin bad++; $display("FAIL reset_fml_adr got=%h exp=0", fml_adr); end
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_refill_only();
    for (int i = 0; i < 8; i++) rdat[i] = 16'hA000 + 16'(i);
    model_cmd(1'b0, 1'b1, 5, '0, 22'h12345, 0, 3, 8);
    run_cmd(1'b0, 1'b1, 5, '0, 22'h12345, 0, 3, -10, -10);
    total++; if (obs_adr_q.size() != 1) begin bad++; $display("FAIL rf_bursts got=%0d exp=1", obs_adr_q.size()); end
    else begin
      total++; if (obs_adr_q[0] !== 26'h0123450) begin bad++; $display("FAIL rf_adr got=%h exp=0123450", obs_adr_q[0]); end
      total++; if (obs_we_q[0] !== 1'b0) begin bad++; $display("FAIL rf_we got=%b exp=0", obs_we_q[0]); end
    end
    total++; if (obs_wa_q.size() != 8) begin bad++; $display("FAIL rf_nwrites got=%0d exp=8", obs_wa_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      total++;
      if (obs_wa_q[i] !== 8'(40 + i) || obs_wdd_q[i] !== 16'hA000 + 16'(i) ||
          obs_wwe_q[i] !== 2'b11 || obs_wc_q[i] !== 5 + i) begin
        bad++;
        $display("FAIL rf_write%0d got=a%0d d%h we%b c%0d exp=a%0d d%h we11 c%0d", i,
                 obs_wa_q[i], obs_wdd_q[i], obs_wwe_q[i], obs_wc_q[i], 40 + i, 16'hA000 + 16'(i), 5 + i);
      end
    end
    total++; if (obs_done_c !== 13) begin bad++; $display("FAIL rf_done_cycle got=%0d exp=13", obs_done_c); end
    total++; if (obs_done_n !== 1) begin bad++; $display("FAIL rf_done_count got=%0d exp=1", obs_done_n); end
  endtask

  task automatic test_writeback_only();
    logic [LW-1:0] ea;
    ea = LW'($urandom);
    for (int k = 0; k < 8; k++) preload(16 + k, 16'hB000 + 16'(k));
    model_cmd(1'b1, 1'b0, 2, ea, '0, 0, 0, 8);
    run_cmd(1'b1, 1'b0, 2, ea, '0, 0, 0, -10, -10);
    total++; if (obs_adr_q.size() != 1) begin bad++; $display("FAIL wb_bursts got=%0d exp=1", obs_adr_q.size()); end
    else begin
      total++; if (obs_adr_q[0] !== {ea, 4'h0}) begin bad++; $display("FAIL wb_adr got=%h exp=%h", obs_adr_q[0], {ea, 4'h0}); end
      total++; if (obs_we_q[0] !== 1'b1) begin bad++; $display("FAIL wb_we got=%b exp=1", obs_we_q[0]); end
      total++; if (obs_sel_q[0] !== 2'b11) begin bad++; $display("FAIL wb_sel got=%b exp=11", obs_sel_q[0]); end
      total++; if (obs_ack_q[0] !== 1) begin bad++; $display("FAIL wb_ack_cycle got=%0d exp=1", obs_ack_q[0]); end
    end
    total++; if (obs_wd_q.size() != 8) begin bad++; $display("FAIL wb_nwords got=%0d exp=8", obs_wd_q.size()); end
    else for (int k = 0; k < 8; k++) begin
      total++;
      if (obs_wd_q[k] !== 16'hB000 + 16'(k)) begin bad++; $display("FAIL wb_word%0d got=%h exp=%h", k, obs_wd_q[k], 16'hB000 + 16'(k)); end
    end
    total++; if (obs_wa_q.size() != 0) begin bad++; $display("FAIL wb_dm_writes got=%0d exp=0", obs_wa_q.size()); end
    total++; if (obs_done_c !== 9) begin bad++; $display("FAIL wb_done_cycle got=%0d exp=9", obs_done_c); end
  endtask

  task automatic test_evict_refill_last();
    logic [LW-1:0] ea, ra;
    logic [15:0] old [8];
    ea = LW'($urandom); ra = LW'($urandom);
    for (int i = 0; i < 8; i++) begin rdat[i] = 16'($urandom); old[i] = mem_exp[248 + i]; end
    model_cmd(1'b1, 1'b1, 31, ea, ra, 0, 0, 8);
    run_cmd(1'b1, 1'b1, 31, ea, ra, 0, 0, -10, -10);
    total++; if (obs_adr_q.size() != 2) begin bad++; $display("FAIL er_bursts got=%0d exp=2", obs_adr_q.size()); end
    else begin
      total++; if (obs_adr_q[0] !== {ea, 4'h0} || obs_we_q[0] !== 1'b1) begin bad++; $display("FAIL er_wb_req got=%h/%b exp=%h/1", obs_adr_q[0], obs_we_q[0], {ea, 4'h0}); end
      total++; if (obs_adr_q[1] !== {ra, 4'h0} || obs_we_q[1] !== 1'b0) begin bad++; $display("FAIL er_rf_req got=%h/%b exp=%h/0", obs_adr_q[1], obs_we_q[1], {ra, 4'h0}); end
    end
    total++; if (obs_wd_q.size() != 8) begin bad++; $display("FAIL er_nwords got=%0d exp=8", obs_wd_q.size()); end
    else for (int k = 0; k < 8; k++) begin
      total++; if (obs_wd_q[k] !== old[k]) begin bad++; $display("FAIL er_word%0d got=%h exp=%h", k, obs_wd_q[k], old[k]); end
    end
    total++; if (obs_wa_q.size() != 8) begin bad++; $display("FAIL er_nwrites got=%0d exp=8", obs_wa_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      total++;
      if (obs_wa_q[i] !== 8'(248 + i) || obs_wdd_q[i] !== rdat[i] || obs_wc_q[i] !== 10 + i) begin
        bad++; $display("FAIL er_write%0d got=a%0d d%h c%0d exp=a%0d d%h c%0d", i, obs_wa_q[i], obs_wdd_q[i], obs_wc_q[i], 248 + i, rdat[i], 10 + i);
      end
    end
    total++; if (obs_done_c !== 18) begin bad++; $display("FAIL er_done_cycle got=%0d exp=18", obs_done_c); end
  endtask

  task automatic test_no_op();
    model_cmd(1'b0, 1'b0, 7, '0, '0, 0, 0, 8);
    run_cmd(1'b0, 1'b0, 7, LW'($urandom), LW'($urandom), 0, 0, -10, -10);
    total++; if (obs_done_c !== 1) begin bad++; $display("FAIL nop_done_cycle got=%0d exp=1", obs_done_c); end
    total++; if (obs_done_n !== 1) begin bad++; $display("FAIL nop_done_count got=%0d exp=1", obs_done_n); end
    total++; if (obs_stb_n !== 0) begin bad++; $display("FAIL nop_stb got=%0d exp=0", obs_stb_n); end
    total++; if (obs_wa_q.size() != 0) begin bad++; $display("FAIL nop_dm_writes got=%0d exp=0", obs_wa_q.size()); end
  endtask

  task automatic test_busy_ignore();
    int idx;
    logic [LW-1:0] ra;
    idx = $urandom_range(0, 31); ra = LW'($urandom);
    for (int i = 0; i < 8; i++) rdat[i] = 16'($urandom);
    model_cmd(1'b0, 1'b1, idx, '0, ra, 0, 0, 8);
    run_cmd(1'b0, 1'b1, idx, '0, ra, 0, 0, 5, -10);
    total++; if (obs_done_n !== 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", obs_done_n); end
    total++; if (obs_done_c !== 10) begin bad++; $display("FAIL busy_done_cycle got=%0d exp=10", obs_done_c); end
    total++; if (obs_adr_q.size() != 1) begin bad++; $display("FAIL busy_bursts got=%0d exp=1", obs_adr_q.size()); end
    total++; if (obs_wa_q.size() != 8) begin bad++; $display("FAIL busy_nwrites got=%0d exp=8", obs_wa_q.size()); end
    // the next command is taken normally once the engine is idle again
    model_cmd(1'b1, 1'b0, idx, ra, '0, 0, 0, 8);
    run_cmd(1'b1, 1'b0, idx, ra, '0, 0, 0, -10, -10);
    total++; if (obs_done_c !== 9) begin bad++; $display("FAIL after_busy_done got=%0d exp=9", obs_done_c); end
    total++; if (obs_wd_q.size() != 8 || obs_wd_q[7] !== exp_wd_q[7]) begin bad++; $display("FAIL after_busy_word7 got=%h exp=%h", obs_wd_q[7], exp_wd_q[7]); end
  endtask

  task automatic test_reset_mid_burst();
    int idx;
    logic [LW-1:0] ra;
    idx = $urandom_range(0, 31); ra = LW'($urandom);
    for (int i = 0; i < 8; i++) rdat[i] = 16'($urandom);
    // words 0..3 land (cycles 2..5); the reset edge ends cycle 5
    model_cmd(1'b0, 1'b1, idx, '0, ra, 0, 0, 4);
    run_cmd(1'b0, 1'b1, idx, '0, ra, 0, 0, -10, 5);
    total++; if (rst_state !== S_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", rst_state, S_IDLE); end
    total++; if (rst_stb !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b exp=0", rst_stb); end
    total++; if (rst_we !== 2'b00) begin bad++; $display("FAIL rst_dm_we got=%b exp=00", rst_we); end
    total++; if (rst_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", rst_busy); end
    total++; if (obs_wa_q.size() != 4) begin bad++; $display("FAIL rst_nwrites got=%0d exp=4", obs_wa_q.size()); end
    total++; if (obs_done_n !== 0) begin bad++; $display("FAIL rst_done got=%0d exp=0", obs_done_n); end
    for (int i = 0; i < 8; i++) rdat[i] = 16'($urandom);
    model_cmd(1'b0, 1'b1, idx, '0, ra, 0, 0, 8);
    run_cmd(1'b0, 1'b1, idx, '0, ra, 0, 0, -10, -10);
    total++; if (obs_done_c !== 10) begin bad++; $display("FAIL post_rst_done got=%0d exp=10", obs_done_c); end
    total++; if (obs_wa_q.size() != 8) begin bad++; $display("FAIL post_rst_nwrites got=%0d exp=8", obs_wa_q.size()); end
  endtask

  task automatic test_random();
    logic ev, rf;
    int idx, de, dr;
    logic [LW-1:0] ea, ra;
    for (int it = 0; it < 12; it++) begin
      ev = 1'($urandom); rf = 1'($urandom);
      idx = $urandom_range(0, 31); de = $urandom_range(0, 3); dr = $urandom_range(0, 3);
      ea = LW'($urandom); ra = LW'($urandom);
      for (int i = 0; i < 8; i++) rdat[i] = 16'($urandom);
      model_cmd(ev, rf, idx, ea, ra, de, dr, 8);
      run_cmd(ev, rf, idx, ea, ra, de, dr, -10, -10);
      total++; if (obs_done_c !== exp_done_c) begin bad++; $display("FAIL rnd%0d_done got=%0d exp=%0d", it, obs_done_c, exp_done_c); end
      total++; if (obs_done_n !== 1) begin bad++; $display("FAIL rnd%0d_done_count got=%0d exp=1", it, obs_done_n); end
      total++; if (obs_adr_q.size() != exp_adr_q.size()) begin bad++; $display("FAIL rnd%0d_bursts got=%0d exp=%0d", it, obs_adr_q.size(), exp_adr_q.size()); end
      else for (int b = 0; b < exp_adr_q.size(); b++) begin
        total++;
        if (obs_adr_q[b] !== exp_adr_q[b] || obs_we_q[b] !== exp_we_q[b]) begin
          bad++; $display("FAIL rnd%0d_req%0d got=%h/%b exp=%h/%b", it, b, obs_adr_q[b], obs_we_q[b], exp_adr_q[b], exp_we_q[b]);
        end
      end
      total++; if (obs_wd_q.size() != exp_wd_q.size()) begin bad++; $display("FAIL rnd%0d_nwords got=%0d exp=%0d", it, obs_wd_q.size(), exp_wd_q.size()); end
      else for (int k = 0; k < exp_wd_q.size(); k++) begin
        total++; if (obs_wd_q[k] !== exp_wd_q[k]) begin bad++; $display("FAIL rnd%0d_word%0d got=%h exp=%h", it, k, obs_wd_q[k], exp_wd_q[k]); end
      end
      total++; if (obs_wa_q.size() != exp_wa_q.size()) begin bad++; $display("FAIL rnd%0d_nwrites got=%0d exp=%0d", it, obs_wa_q.size(), exp_wa_q.size()); end
      else for (int i = 0; i < exp_wa_q.size(); i++) begin
        total++;
        if (obs_wa_q[i] !== exp_wa_q[i] || obs_wdd_q[i] !== exp_wdd_q[i] || obs_wc_q[i] !== exp_wc_q[i]) begin
          bad++; $display("FAIL rnd%0d_write%0d got=a%0d d%h c%0d exp=a%0d d%h c%0d", it, i,
                          obs_wa_q[i], obs_wdd_q[i], obs_wc_q[i], exp_wa_q[i], exp_wdd_q[i], exp_wc_q[i]);
        end
      end
    end
    // whole memory image against the model: catches stray or missing writes
    for (int a = 0; a < 256; a++) begin
      total++; if (mem[a] !== mem_exp[a]) begin bad++; $display("FAIL mem%0d got=%h exp=%h", a, mem[a], mem_exp[a]); end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req_valid = 1'b0; req_evict = 1'b0; req_refill = 1'b0;
    req_index = '0; evict_ladr = '0; refill_ladr = '0;
    fml_di = '0; fml_ack = 1'b0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
    test_reset();
    preload_all();
    test_refill_only();
    test_writeback_only();
    test_evict_refill_last();
    test_no_op();
    test_busy_ignore();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
